// File: rtl/light_seq_pkg.sv
// Shared types and constants for the light sequencer.
package light_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  localparam logic [1:0] MODE_UP      = 2'd0;
  localparam logic [1:0] MODE_DN      = 2'd1;
  localparam logic [1:0] MODE_BOUNCE  = 2'd2;
  localparam logic [1:0] MODE_ONESHOT = 2'd3;

  // One-hot LED pattern for a position.
  function automatic logic [7:0] onehot(input logic [2:0] p);
    return 8'd1 << p;
  endfunction

endpackage

// File: rtl/tick_divider.sv
// Free-running base divider: counts 0..DIV_N-1 and flags the last count.
module tick_divider #(
  parameter int DIV_N = 10,
  parameter int W     = (DIV_N > 1) ? $clog2(DIV_N) : 1
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam logic [W-1:0] LAST = W'(DIV_N - 1);

  logic [W-1:0] count;

  assign tick = (count == LAST);

  // Wrap to zero on the tick cycle, otherwise increment.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    count <= '0;
    else if (tick) count <= '0;
    else           count <= count + W'(1);
  end

endmodule

// File: rtl/light_seq_ctrl.sv
// Running-light sequencer: IDLE/RUN/PAUSE FSM stepping a one-hot LED
// through flow-up, flow-down, bounce and one-shot bounce patterns.
// Optional macro LIGHT_SEQ_BLINK_EN: blink the lit LED on every base tick
// while paused (default build holds it steady).
module light_seq_ctrl
  import light_seq_pkg::*;
#(
  parameter int SIM   = 0,
  parameter int DIV_N = (SIM != 0) ? 10 : 50_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       pause,
  input  logic       stop,
  input  logic [1:0] mode,
  input  logic [1:0] speed,
  output logic [7:0] led,
  output logic [2:0] pos,
  output logic       dir,
  output logic       busy,
  output logic       step,
  output logic       done
);

  state_t     state_q, state_d;
  logic [1:0] mode_q, mode_d;
  logic [2:0] pos_d;
  logic       dir_d;
  logic [2:0] presc_q, presc_d;
  logic [2:0] presc_max;
  logic [7:0] led_d;
  logic       busy_d, step_d, done_d;
  logic       tick;

  tick_divider #(.DIV_N(DIV_N)) u_div (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  // Speed is applied live: 2^speed base ticks per step.
  assign presc_max = 3'((4'd1 << speed) - 4'd1);

  // Next-state, datapath and registered-output values.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    pos_d   = pos;
    dir_d   = dir;
    presc_d = presc_q;
    step_d  = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (!stop && start) begin
          state_d = RUN;
          mode_d  = mode;
          presc_d = '0;
          if (mode == MODE_DN) begin
            pos_d = 3'd7;
            dir_d = 1'b0;
          end else begin
            pos_d = 3'd0;
            dir_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (pause && !start) begin
          state_d = PAUSE;
        end else if (tick) begin
          if (presc_q >= presc_max) begin
            presc_d = '0;
            step_d  = 1'b1;
            case (mode_q)
              MODE_UP: pos_d = pos + 3'd1;
              MODE_DN: pos_d = pos - 3'd1;
              default: begin
                if (dir) begin
                  if (pos == 3'd7) begin
                    pos_d = 3'd6;
                    dir_d = 1'b0;
                  end else begin
                    pos_d = pos + 3'd1;
                  end
                end else begin
                  if (pos == 3'd0) begin
                    pos_d = 3'd1;
                    dir_d = 1'b1;
                  end else begin
                    pos_d = pos - 3'd1;
                  end
                end
              end
            endcase
            // One-shot ends on the downward arrival at position 0.
            if (mode_q == MODE_ONESHOT && !dir && pos == 3'd1) begin
              done_d  = 1'b1;
              state_d = IDLE;
              pos_d   = 3'd0;
              dir_d   = 1'b1;
            end
          end else begin
            presc_d = presc_q + 3'd1;
          end
        end
      end
      PAUSE: begin
        if (start) state_d = RUN;
      end
      default: state_d = IDLE;
    endcase

    // Stop overrides everything else.
    if (stop) begin
      state_d = IDLE;
      pos_d   = 3'd0;
      dir_d   = 1'b1;
      presc_d = '0;
      step_d  = 1'b0;
      done_d  = 1'b0;
    end

    if (state_d == IDLE) begin
      led_d = 8'h00;
    end else if (state_q == PAUSE && state_d == PAUSE) begin
`ifdef LIGHT_SEQ_BLINK_EN
      if (tick) led_d = (led == 8'h00) ? onehot(pos) : 8'h00;
      else      led_d = led;
`else
      led_d = onehot(pos);
`endif
    end else begin
      led_d = onehot(pos_d);
    end

    busy_d = (state_d != IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      mode_q  <= MODE_UP;
      pos     <= 3'd0;
      dir     <= 1'b1;
      presc_q <= '0;
      led     <= 8'h00;
      busy    <= 1'b0;
      step    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      pos     <= pos_d;
      dir     <= dir_d;
      presc_q <= presc_d;
      led     <= led_d;
      busy    <= busy_d;
      step    <= step_d;
      done    <= done_d;
    end
  end

endmodule

// File: tb/tb_light_seq_ctrl.sv
// Scoreboard bench for light_seq_ctrl (SIM=1, DIV_N=10).
module tb_light_seq_ctrl;
  import light_seq_pkg::*;

  logic       clk = 1'b0, reset = 1'b0;
  logic       start = 1'b0, pause = 1'b0, stop = 1'b0;
  logic [1:0] mode = 2'd0, speed = 2'd0;
  logic [7:0] led;
  logic [2:0] pos;
  logic       dir, busy, step, done;

  light_seq_ctrl #(.SIM(1), .DIV_N(10)) dut (
    .clk(clk), .reset(reset), .start(start), .pause(pause), .stop(stop),
    .mode(mode), .speed(speed), .led(led), .pos(pos), .dir(dir),
    .busy(busy), .step(step), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] pos;
    logic       dir;
    logic       done;
    logic       full;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0, errors = 0;
  int   cyc = 0, last_step = -1, exp_period = 10;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic push(input logic [2:0] p, input logic d, input logic dn, input logic full);
    exp_t e;
    e.pos = p; e.dir = d; e.done = dn; e.full = full;
    exp_q.push_back(e);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Compare every step pulse against the next expected entry.
  always @(negedge clk) begin
    if (reset) begin
      if (done && !step) chk("done_stray", 1, 0);
      if (step) begin
        if (exp_q.size() == 0) begin
          chk("step_unexp", {29'd0, pos}, 32'hFFFF_FFFF);
        end else begin
          mon_e = exp_q.pop_front();
          chk("step_pos", pos, mon_e.pos);
          chk("step_done", done, mon_e.done);
          if (mon_e.full) begin
            chk("step_dir", dir, mon_e.dir);
            chk("step_led", led, onehot(mon_e.pos));
          end
          if (last_step >= 0) chk("step_period", cyc - last_step, exp_period);
          last_step = cyc;
        end
      end
    end
  end

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic do_stop(input string tag);
    @(negedge clk) stop = 1'b1;
    @(negedge clk) stop = 1'b0;
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_led"}, led, 8'h00);
    chk({tag, "_pos"}, pos, 0);
  endtask

  task automatic wait_empty(input string tag, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    chk({tag, "_drained"}, exp_q.size() == 0, 1);
    exp_q.delete();
  endtask

  initial begin
    int bad_pos, bad_led;
    logic seen_on, seen_off;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_pos", pos, 0);
    chk("rst_dir", dir, 1);
    chk("rst_led", led, 8'h00);
    chk("rst_busy", busy, 0);
    chk("rst_step", step, 0);
    chk("rst_done", done, 0);
    @(negedge clk) reset = 1'b1;

    // Mode 0 flow up, speed 0
    mode = MODE_UP; speed = 2'd0; exp_period = 10; last_step = -1;
    for (int i = 1; i <= 9; i++) push(3'(i % 8), 1'b1, 1'b0, 1'b1);
    pulse_start();
    chk("m0_start_pos", pos, 0);
    chk("m0_start_led", led, 8'h01);
    chk("m0_start_busy", busy, 1);
    wait_empty("m0", 150);
    do_stop("m0_stop");

    // Mode 2 bounce, speed 1
    mode = MODE_BOUNCE; speed = 2'd1; exp_period = 20; last_step = -1;
    for (int p = 1; p <= 7; p++) push(3'(p), 1'b1, 1'b0, 1'b1);
    for (int p = 6; p >= 0; p--) push(3'(p), 1'b0, 1'b0, 1'b1);
    push(3'd1, 1'b1, 1'b0, 1'b1);
    pulse_start();
    wait_empty("m2", 400);
    do_stop("m2_stop");

    // Mode 3 one-shot bounce
    mode = MODE_ONESHOT; speed = 2'd0; exp_period = 10; last_step = -1;
    for (int p = 1; p <= 7; p++) push(3'(p), 1'b1, 1'b0, 1'b1);
    for (int p = 6; p >= 1; p--) push(3'(p), 1'b0, 1'b0, 1'b1);
    push(3'd0, 1'b0, 1'b1, 1'b0);
    pulse_start();
    wait_empty("m3", 250);
    @(negedge clk);
    chk("m3_after_busy", busy, 0);
    chk("m3_after_led", led, 8'h00);
    chk("m3_after_done", done, 0);
    repeat (25) @(negedge clk);

    // Pause at pos 3, hold 50 cycles, resume
    mode = MODE_UP; speed = 2'd0; last_step = -1;
    for (int p = 1; p <= 3; p++) push(3'(p), 1'b1, 1'b0, 1'b1);
    pulse_start();
    wait_empty("pz_run", 60);
    @(negedge clk) pause = 1'b1;
    @(negedge clk) pause = 1'b0;
    chk("pz_busy", busy, 1);
    bad_pos = 0; bad_led = 0; seen_on = 1'b0; seen_off = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (pos !== 3'd3) bad_pos++;
      if (led === 8'h08) seen_on = 1'b1;
      else if (led === 8'h00) seen_off = 1'b1;
      else bad_led++;
    end
    chk("pz_pos_hold", bad_pos, 0);
    chk("pz_led_other", bad_led, 0);
`ifdef LIGHT_SEQ_BLINK_EN
    chk("pz_led_blink", {seen_on, seen_off}, 2'b11);
`else
    chk("pz_led_hold", {seen_on, seen_off}, 2'b10);
`endif
    last_step = -1;
    push(3'd4, 1'b1, 1'b0, 1'b1);
    push(3'd5, 1'b1, 1'b0, 1'b1);
    pulse_start();
    chk("pz_resume_pos", pos, 3);
    chk("pz_resume_led", led, 8'h08);
    wait_empty("pz_resume", 60);
    do_stop("pz_stop");

    // start+pause+stop in the same RUN cycle
    pulse_start();
    @(negedge clk) begin start = 1'b1; pause = 1'b1; stop = 1'b1; end
    @(negedge clk) begin start = 1'b0; pause = 1'b0; stop = 1'b0; end
    chk("all3_busy", busy, 0);
    chk("all3_led", led, 8'h00);

    // Asynchronous reset at pos 5
    last_step = -1;
    for (int p = 1; p <= 5; p++) push(3'(p), 1'b1, 1'b0, 1'b1);
    pulse_start();
    wait_empty("ar_run", 100);
    @(negedge clk);
    #1 reset = 1'b0;
    #1;
    chk("ar_pos", pos, 0);
    chk("ar_dir", dir, 1);
    chk("ar_led", led, 8'h00);
    chk("ar_busy", busy, 0);
    chk("ar_flags", {step, done}, 2'b00);
    @(negedge clk) reset = 1'b1;

    // Mode 1 flow down; mode change mid-run is ignored
    mode = MODE_DN; speed = 2'd0; last_step = -1;
    for (int p = 6; p >= 0; p--) push(3'(p), 1'b0, 1'b0, 1'b1);
    push(3'd7, 1'b0, 1'b0, 1'b1);
    pulse_start();
    mode = MODE_UP;
    chk("m1_start_pos", pos, 7);
    chk("m1_start_dir", dir, 0);
    chk("m1_start_led", led, 8'h80);
    wait_empty("m1", 150);
    do_stop("m1_stop");

    repeat (20) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/light_seq_ctrl.md
LIGHT_SEQ_CTRL -- requirements
Module: light_seq_ctrl

Interface
REQ-001 Parameter SIM, default 0: 1 selects the simulation divider ratio, 0 the board ratio.
REQ-002 Parameter DIV_N, default SIM?10:50_000_000: base tick period in clk cycles.
REQ-003 clk  input  1  system clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  level-sampled; starts a sequence from IDLE, resumes from PAUSE.
REQ-006 pause  input  1  level-sampled; RUN -> PAUSE.
REQ-007 stop  input  1  level-sampled; any state -> IDLE.
REQ-008 mode  input  2  sequence type: 0 flow up, 1 flow down, 2 bounce, 3 one-shot bounce.
REQ-009 speed  input  2  step period = base tick period x 2^speed.
REQ-010 led  output  8  one-hot position display, registered.
REQ-011 pos  output  3  current position.
REQ-012 dir  output  1  current travel direction: 1 up, 0 down.
REQ-013 busy  output  1  high when state is not IDLE.
REQ-014 step  output  1  one-cycle pulse in the cycle pos changes.
REQ-015 done  output  1  one-cycle pulse when a mode-3 sequence completes.

Function
REQ-016 Base divider: free-running count 0..DIV_N-1; base tick pulses for 1 cycle when count = DIV_N-1, then count wraps to 0.
REQ-017 Prescaler: counts base ticks 0..2^speed-1; step fires on the base tick where prescaler = 2^speed-1; speed is sampled live.
REQ-018 FSM states IDLE, RUN, PAUSE; input priority stop > start > pause.
REQ-019 IDLE + start -> RUN: latch mode; prescaler cleared; pos = 7, dir = 0 for mode 1; pos = 0, dir = 1 otherwise.
REQ-020 RUN + pause -> PAUSE; PAUSE + start -> RUN with pos, dir, and prescaler preserved; no step fires in PAUSE.
REQ-021 stop in any state -> IDLE next cycle; pos = 0, dir = 1, led = 0.
REQ-022 Mode 0 step: pos+1, wraps 7 -> 0.
REQ-023 Mode 1 step: pos-1, wraps 0 -> 7.
REQ-024 Mode 2 step: moves in dir; at pos 7 going up -> pos 6, dir = 0; at pos 0 going down -> pos 1, dir = 1; no end value repeats.
REQ-025 Mode 3: same as mode 2, except the step that reaches pos 0 while dir = 0 asserts done that cycle and enters IDLE.
REQ-026 Changes on mode during RUN or PAUSE are ignored until the next start from IDLE.
REQ-027 led = 1 << pos in RUN and PAUSE; led = 0 in IDLE; all outputs registered.

Reset
REQ-028 While reset is 0: state = IDLE, divider = 0, prescaler = 0, pos = 0, dir = 1, led = 0, busy/step/done = 0.
REQ-029 Reset asserted mid-sequence aborts immediately, with no done pulse.

Configuration
REQ-030 Macro LIGHT_SEQ_BLINK_EN defined: in PAUSE, led toggles between 1<<pos and 8'h00 on every base tick, starting lit on PAUSE entry.
REQ-031 Macro LIGHT_SEQ_BLINK_EN undefined: in PAUSE, led holds 1<<pos.
REQ-032 In both cases the macro changes no port and no other behaviour.

Structure
REQ-033 Package light_seq_pkg holds the state enum (IDLE, RUN, PAUSE) and the mode constants (MODE_UP, MODE_DN, MODE_BOUNCE, MODE_ONESHOT).
REQ-034 One sub-module, tick_divider (DIV_N, width = clog2(DIV_N)), produces the base tick; all other logic stays in light_seq_ctrl.

Verification (SIM=1, DIV_N=10)
REQ-035 Mode 0, speed 0, pulse start -> step every 10 cycles; pos 0,1,...,7,0; led 01,02,...,80,01.
REQ-036 Mode 2, speed 1 -> step every 20 cycles; pos 0..7,6..0,1; dir flips at 7 and at 0.
REQ-037 Mode 3 -> pos 0..7..0, then done for exactly 1 cycle; busy = 0 and led = 00 on the next cycle.
REQ-038 pause at pos 3, hold 50 cycles, then start -> pos stays 3 while paused; resumes 3 -> 4; led blinks only with LIGHT_SEQ_BLINK_EN.
REQ-039 start, pause, and stop asserted in the same cycle during RUN -> IDLE, led = 00; reset pulsed at pos 5 -> all outputs at reset values asynchronously.
REQ-040 Mode 1 start -> pos 7; the first step gives pos 6; mode changed to 0 mid-run -> still decrements, wraps 0 -> 7.
